// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and the bit-period helper
// that the transmitter uses as well.
package uart_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_DATA  = 3'd2;
    localparam logic [2:0] ST_STOP  = 3'd3;
    localparam logic [2:0] ST_BREAK = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_START = ST_START,
        S_DATA  = ST_DATA,
        S_STOP  = ST_STOP,
        S_BREAK = ST_BREAK
    } uart_state_t;

    function automatic int clks_per_bit(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input; the reset value
// is chosen to match the input's idle level.
module sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, idle-high line. Good bytes are written to the
// downstream FIFO with a one-cycle strobe; framing errors and overruns pulse.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    input  logic       full,
    output logic [7:0] data,
    output logic       wr,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int DIV  = clks_per_bit(CLK_FREQ, BAUD_RATE);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV) + 1;

    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);

    logic        rxs;
    uart_state_t state;
    logic [CW-1:0] ctr;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;

    sync2 #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rxs)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ctr       <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            data      <= '0;
            wr        <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            // NOTE: pulses default low every cycle so each fires for exactly one clock.
            wr        <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            ctr       <= ctr + 1'b1;

            case (state)
                S_IDLE: begin
                    ctr <= '0;
                    if (!rxs) begin
                        state <= S_START;
                        busy  <= 1'b1;
                    end
                end

                S_START: begin
                    if (ctr == HALF_M1) begin
                        ctr <= '0;
                        if (rxs) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                        end else begin
                            state   <= S_DATA;
                            bit_cnt <= '0;
                        end
                    end
                end

                S_DATA: begin
                    if (ctr == DIV_M1) begin
                        ctr     <= '0;
                        shreg   <= {rxs, shreg[7:1]};
                        bit_cnt <= bit_cnt + 1'b1;
                        if (bit_cnt == 3'd7)
                            state <= S_STOP;
                    end
                end

                // Leaving here mid-stop-bit lets a back-to-back start bit be caught.
                S_STOP: begin
                    if (ctr == DIV_M1) begin
                        ctr <= '0;
                        if (rxs) begin
                            state <= S_IDLE;
                            busy  <= 1'b0;
                            if (full) begin
                                overrun <= 1'b1;
                            end else begin
                                data <= shreg;
                                wr   <= 1'b1;
                            end
                        end else begin
                            state     <= S_BREAK;
                            frame_err <= 1'b1;
                        end
                    end
                end

                S_BREAK: begin
                    ctr <= '0;
                    if (rxs) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                    ctr   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at DIV=16: directed frames plus randomized
// frames compared against a frame-level outcome model.
module tb_uart_rx;

    localparam int CLK_FREQ  = 1_600_000;
    localparam int BAUD_RATE = 100_000;

    typedef enum int {EV_WR = 0, EV_FE = 1, EV_OV = 2} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [7:0]  d;
        int          cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic       full;
    logic [7:0] data;
    logic       wr;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int   cyc = 0;
    int   multi_pulse = 0;
    int   vectors = 0;
    int   miscompares = 0;
    ev_t  obs_q[$];
    ev_t  exp_q[$];
    logic [7:0] exp_data = 8'h00;

    uart_rx #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD_RATE)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .full      (full),
        .data      (data),
        .wr        (wr),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every output pulse, sampled mid-cycle.
    always @(negedge clk) begin
        if ((int'(wr) + int'(frame_err) + int'(overrun)) > 1)
            multi_pulse <= multi_pulse + 1;
        if (wr)        obs_q.push_back('{EV_WR, data, cyc});
        if (frame_err) obs_q.push_back('{EV_FE, 8'h00, cyc});
        if (overrun)   obs_q.push_back('{EV_OV, 8'h00, cyc});
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame-level reference: the outcome depends only on stop level and full.
    task automatic model_frame(input logic [7:0] d, input bit stop_ok, input bit full_at_stop);
        if (!stop_ok) begin
            exp_q.push_back('{EV_FE, 8'h00, 0});
        end else if (full_at_stop) begin
            exp_q.push_back('{EV_OV, 8'h00, 0});
        end else begin
            exp_q.push_back('{EV_WR, d, 0});
            exp_data = d;
        end
    endtask

    task automatic check_events(input string tag);
        int n;
        check({tag, "_count"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check({tag, "_kind"}, obs_q[i].kind, exp_q[i].kind);
            check({tag, "_data"}, obs_q[i].d, exp_q[i].d);
        end
        obs_q.delete();
        exp_q.delete();
    endtask

    // Called just after a rising edge; holds rx for n edges.
    task automatic drive(input logic lvl, input int n);
        rx = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // per = bit period in hundredths of a clock, so baud offsets can be fractional.
    task automatic send_frame(input logic [7:0] d, input bit stop, input int per);
        int   prev;
        int   nxt;
        logic lvl;
        prev = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 0)      lvl = 1'b0;
            else if (i == 9) lvl = stop;
            else             lvl = d[i-1];
            nxt = ((i + 1) * per + 50) / 100;
            drive(lvl, nxt - prev);
            prev = nxt;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_data"}, data, 8'h00);
        check({tag, "_wr"}, wr, 1'b0);
        check({tag, "_ferr"}, frame_err, 1'b0);
        check({tag, "_ovr"}, overrun, 1'b0);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int         c0;
        logic [7:0] rb;
        logic [7:0] b77;
        bit         rstop;
        bit         rfull;
        int         rper;

        rst = 1'b0; rx = 1'b1; full = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1'b1, 20);

        // 0xA5 at nominal rate; wr rises on edge 2+HALF+9*DIV = 154 after cycle 0.
        c0 = cyc + 1;
        send_frame(8'hA5, 1'b1, 1600);
        drive(1'b1, 20);
        check("a5_latency", (obs_q.size() > 0) ? obs_q[0].cyc - c0 : -1, 154);
        model_frame(8'hA5, 1'b1, 1'b0);
        check_events("a5");
        check("a5_data_port", data, exp_data);

        // Short low glitch: START entered at edge 2, rejected at edge 10.
        drive(1'b0, 4);
        rx = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check("glitch_busy_high", busy, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("glitch_busy_low", busy, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 20);
        check_events("glitch");

        // Low stop bit, line held low: frame error and BREAK until the line rises.
        send_frame(8'h3C, 1'b0, 1600);
        drive(1'b0, 40);
        @(negedge clk);
        check("break_busy_held", busy, 1'b1);
        @(posedge clk); #1;
        drive(1'b1, 5);
        @(negedge clk);
        check("break_busy_released", busy, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 10);
        model_frame(8'h3C, 1'b0, 1'b0);
        check_events("ferr");

        send_frame(8'h81, 1'b1, 1600);
        drive(1'b1, 20);
        model_frame(8'h81, 1'b1, 1'b0);
        check_events("after_break");
        check("after_break_data", data, exp_data);

        // Downstream full at the stop sample: overrun, data unchanged.
        full = 1'b1;
        send_frame(8'h5A, 1'b1, 1600);
        full = 1'b0;
        drive(1'b1, 20);
        model_frame(8'h5A, 1'b1, 1'b1);
        check_events("overrun");
        check("overrun_data_kept", data, exp_data);

        // Back-to-back frames, 3% fast, no idle gap.
        send_frame(8'h00, 1'b1, 1553);
        send_frame(8'hFF, 1'b1, 1553);
        drive(1'b1, 20);
        model_frame(8'h00, 1'b1, 1'b0);
        model_frame(8'hFF, 1'b1, 1'b0);
        check_events("b2b");

        // Reset during data bit 4 of 0x77.
        b77 = 8'h77;
        drive(1'b0, 16);
        for (int k = 0; k < 4; k++) drive(b77[k], 16);
        drive(b77[4], 8);
        rst = 1'b0;
        rx  = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_reset_outputs("midframe_reset");
        end
        @(posedge clk); #1;
        rst = 1'b1;
        exp_data = 8'h00;
        drive(1'b1, 20);
        check_events("midframe_reset");

        send_frame(8'h12, 1'b1, 1600);
        drive(1'b1, 20);
        model_frame(8'h12, 1'b1, 1'b0);
        check_events("post_reset");
        check("post_reset_data", data, exp_data);

        // Randomized frames within +/-2% baud, occasional bad stop bits and full FIFO.
        for (int n = 0; n < 24; n++) begin
            rb    = 8'($urandom);
            rstop = ($urandom_range(0, 5) != 0);
            rfull = ($urandom_range(0, 3) == 0);
            rper  = 1568 + int'($urandom_range(0, 64));
            full  = rfull;
            send_frame(rb, rstop, rper);
            full  = 1'b0;
            drive(1'b1, 12 + int'($urandom_range(0, 8)));
            model_frame(rb, rstop, rfull);
            check_events("random");
            check("random_data", data, exp_data);
            check("random_idle_busy", busy, 1'b0);
        end

        check("pulse_exclusive", multi_pulse, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
